// File: rtl/mer_meter_param.sv
// Modulation-error-ratio meter: phase-select delay line, 4/2-ASK slicer
// against a self-estimated reference, and windowed error statistics.
module mer_meter_param #(
   parameter int  DATA_W    = 18,
   parameter int  PHASES    = 4,
   parameter int  LOG2_SYMS = 20,
   localparam int SEL_W     = $clog2(PHASES)
) (
   input  logic                       sys_clk,
   input  logic                       reset,
   input  logic                       sam_clk_en,
   input  logic                       sym_clk_en,
   input  logic signed [DATA_W-1:0]   dec_in,
   input  logic        [SEL_W-1:0]    phase_sel,
   input  logic                       mode,
   input  logic                       start,
   input  logic                       continuous,
   output logic                       busy,
   output logic                       done,
   output logic signed [DATA_W-1:0]   ref_lvl,
   output logic signed [DATA_W-1:0]   err_avg,
   output logic        [2*DATA_W-1:0] err_sq_avg,
   output logic        [1:0]          slice
);

   localparam int EW = DATA_W + 2;
   localparam int AW = DATA_W + LOG2_SYMS;
   localparam int QW = 2 * DATA_W + LOG2_SYMS;

   localparam logic signed [EW-1:0] MAX_X = EW'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [EW-1:0] MIN_X = ~MAX_X;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WARM = 2'd1;
   localparam logic [1:0] S_MEAS = 2'd2;

   function automatic logic signed [DATA_W-1:0] sat(
      input logic signed [EW-1:0] v
   );
      if (v > MAX_X) begin
         return MAX_X[DATA_W-1:0];
      end else if (v < MIN_X) begin
         return MIN_X[DATA_W-1:0];
      end
      return v[DATA_W-1:0];
   endfunction

   logic signed [DATA_W-1:0]   dly_q [PHASES-1];
   logic signed [DATA_W-1:0]   dly_d [PHASES-1];
   logic signed [DATA_W-1:0]   dec_var_q, dec_var_d;
   logic signed [DATA_W-1:0]   tap;
   logic                       acc_en_q, acc_en_d;
   logic        [1:0]          state_q, state_d;
   logic        [LOG2_SYMS-1:0] cnt_q, cnt_d;
   logic        [AW-1:0]       abs_sum_q, abs_sum_d;
   logic signed [AW-1:0]       err_sum_q, err_sum_d;
   logic        [QW-1:0]       sq_sum_q, sq_sum_d;
   logic signed [DATA_W-1:0]   ref_lvl_q, ref_lvl_d;
   logic signed [DATA_W-1:0]   err_avg_q, err_avg_d;
   logic        [2*DATA_W-1:0] err_sq_avg_q, err_sq_avg_d;
   logic                       done_q, done_d;

   logic signed [EW-1:0]       d_x, r_x, half_x, three_x;
   logic signed [EW-1:0]       lvl_x, lvl_sx, err_x, abs_x;
   logic signed [DATA_W-1:0]   lvl_sat, err_sat;
   logic        [DATA_W-1:0]   abs_v;
   logic signed [2*DATA_W-1:0] sq;
   logic        [1:0]          slice_c;
   logic        [AW-1:0]       abs_nx;
   logic signed [AW-1:0]       err_nx;
   logic        [QW-1:0]       sq_nx;
   logic                       win_end;

   always_comb begin
      dly_d = dly_q;
      if (sam_clk_en) begin
         dly_d[0] = dec_in;
         for (int i = 1; i < PHASES - 1; i++) begin
            dly_d[i] = dly_q[i-1];
         end
      end
   end

   always_comb begin
      tap = dec_in;
      for (int i = 1; i < PHASES; i++) begin
         if (int'(phase_sel) == i) begin
            tap = dly_q[i-1];
         end
      end
   end

   assign dec_var_d = sym_clk_en ? tap : dec_var_q;
   assign acc_en_d  = sym_clk_en;

   // Slicer; a value sitting exactly on a threshold takes the upper level.
   always_comb begin
      d_x     = {{2{dec_var_q[DATA_W-1]}}, dec_var_q};
      r_x     = {{2{ref_lvl_q[DATA_W-1]}}, ref_lvl_q};
      half_x  = r_x >>> 1;
      three_x = r_x + half_x;
      lvl_x   = '0;
      slice_c = 2'b00;
      if (mode) begin
         if (d_x >= 0) begin
            lvl_x   = r_x;
            slice_c = 2'b11;
         end else begin
            lvl_x   = -r_x;
            slice_c = 2'b00;
         end
      end else begin
         if (d_x >= r_x) begin
            lvl_x   = three_x;
            slice_c = 2'b11;
         end else if (d_x >= 0) begin
            lvl_x   = half_x;
            slice_c = 2'b10;
         end else if (d_x >= -r_x) begin
            lvl_x   = -half_x;
            slice_c = 2'b01;
         end else begin
            lvl_x   = -three_x;
            slice_c = 2'b00;
         end
      end
      // Without a reference there is no decision; this keeps reset all-zero.
      if (ref_lvl_q == '0) begin
         slice_c = 2'b00;
      end
   end

   always_comb begin
      lvl_sat = sat(lvl_x);
      lvl_sx  = {{2{lvl_sat[DATA_W-1]}}, lvl_sat};
      err_x   = d_x - lvl_sx;
      err_sat = sat(err_x);
      sq      = err_sat * err_sat;
      abs_x   = d_x[EW-1] ? -d_x : d_x;
      abs_v   = (abs_x > MAX_X) ? MAX_X[DATA_W-1:0] : abs_x[DATA_W-1:0];
   end

   always_comb begin
      abs_nx = abs_sum_q + {{LOG2_SYMS{1'b0}}, abs_v};
      err_nx = err_sum_q + {{LOG2_SYMS{err_sat[DATA_W-1]}}, err_sat};
      sq_nx  = sq_sum_q + {{LOG2_SYMS{1'b0}}, sq};
   end

   assign win_end = acc_en_q && (state_q != S_IDLE) && (cnt_q == '1);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      abs_sum_d    = abs_sum_q;
      err_sum_d    = err_sum_q;
      sq_sum_d     = sq_sum_q;
      ref_lvl_d    = ref_lvl_q;
      err_avg_d    = err_avg_q;
      err_sq_avg_d = err_sq_avg_q;
      done_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_WARM;
               cnt_d     = '0;
               abs_sum_d = '0;
               err_sum_d = '0;
               sq_sum_d  = '0;
            end
         end
         S_WARM: begin
            if (win_end) begin
               ref_lvl_d = abs_nx[AW-1:LOG2_SYMS];
               cnt_d     = '0;
               abs_sum_d = '0;
               err_sum_d = '0;
               sq_sum_d  = '0;
               state_d   = S_MEAS;
            end else if (acc_en_q) begin
               abs_sum_d = abs_nx;
               cnt_d     = cnt_q + LOG2_SYMS'(1);
            end
         end
         S_MEAS: begin
            if (win_end) begin
               ref_lvl_d    = abs_nx[AW-1:LOG2_SYMS];
               err_avg_d    = err_nx[AW-1:LOG2_SYMS];
               err_sq_avg_d = sq_nx[QW-1:LOG2_SYMS];
               done_d       = 1'b1;
               cnt_d        = '0;
               abs_sum_d    = '0;
               err_sum_d    = '0;
               sq_sum_d     = '0;
               state_d      = continuous ? S_MEAS : S_IDLE;
            end else if (acc_en_q) begin
               abs_sum_d = abs_nx;
               err_sum_d = err_nx;
               sq_sum_d  = sq_nx;
               cnt_d     = cnt_q + LOG2_SYMS'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < PHASES - 1; i++) begin
            dly_q[i] <= '0;
         end
         dec_var_q    <= '0;
         acc_en_q     <= 1'b0;
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         abs_sum_q    <= '0;
         err_sum_q    <= '0;
         sq_sum_q     <= '0;
         ref_lvl_q    <= '0;
         err_avg_q    <= '0;
         err_sq_avg_q <= '0;
         done_q       <= 1'b0;
      end else begin
         dly_q        <= dly_d;
         dec_var_q    <= dec_var_d;
         acc_en_q     <= acc_en_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         abs_sum_q    <= abs_sum_d;
         err_sum_q    <= err_sum_d;
         sq_sum_q     <= sq_sum_d;
         ref_lvl_q    <= ref_lvl_d;
         err_avg_q    <= err_avg_d;
         err_sq_avg_q <= err_sq_avg_d;
         done_q       <= done_d;
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign ref_lvl    = ref_lvl_q;
   assign err_avg    = err_avg_q;
   assign err_sq_avg = err_sq_avg_q;
   assign slice      = slice_c;

endmodule

// File: tb/tb_mer_meter_param.sv
// Bench for mer_meter_param: directed and random symbol windows checked
// against an arithmetic reference model of the slicer and the averages.
module tb_mer_meter_param;

   localparam int DW = 18;
   localparam int PH = 4;
   localparam int L  = 4;
   localparam int N  = 1 << L;
   localparam int SW = $clog2(PH);

   logic                   sys_clk = 1'b0;
   logic                   reset;
   logic                   sam_clk_en;
   logic                   sym_clk_en;
   logic signed [DW-1:0]   dec_in;
   logic        [SW-1:0]   phase_sel;
   logic                   mode;
   logic                   start;
   logic                   continuous;
   logic                   busy;
   logic                   done;
   logic signed [DW-1:0]   ref_lvl;
   logic signed [DW-1:0]   err_avg;
   logic        [2*DW-1:0] err_sq_avg;
   logic        [1:0]      slice;

   int nvec = 0;
   int nerr = 0;
   int done_cnt = 0;
   int dvq[$];
   int clean[4] = '{32768, 98304, -32768, -98304};

   mer_meter_param #(
      .DATA_W(DW),
      .PHASES(PH),
      .LOG2_SYMS(L)
   ) dut (
      .sys_clk(sys_clk),
      .reset(reset),
      .sam_clk_en(sam_clk_en),
      .sym_clk_en(sym_clk_en),
      .dec_in(dec_in),
      .phase_sel(phase_sel),
      .mode(mode),
      .start(start),
      .continuous(continuous),
      .busy(busy),
      .done(done),
      .ref_lvl(ref_lvl),
      .err_avg(err_avg),
      .err_sq_avg(err_sq_avg),
      .slice(slice)
   );

   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (done === 1'b1) done_cnt++;
   end

   function automatic int sat(input int v);
      if (v > 131071) return 131071;
      if (v < -131072) return -131072;
      return v;
   endfunction

   function automatic int lvl_of(input int d, input int r, input bit m);
      if (m) return (d >= 0) ? r : -r;
      if (d >= r) return sat(r + r / 2);
      if (d >= 0) return r / 2;
      if (d >= -r) return -(r / 2);
      return sat(-(r + r / 2));
   endfunction

   function automatic int slc_of(input int d, input int r, input bit m);
      if (r == 0) return 0;
      if (m) return (d >= 0) ? 3 : 0;
      if (d >= r) return 3;
      if (d >= 0) return 2;
      if (d >= -r) return 1;
      return 0;
   endfunction

   task automatic model(input int v[$], input int r, input bit m,
                        output int rr, output int ea, output longint sq);
      longint as, es, ss;
      int a, e;
      as = 0;
      es = 0;
      ss = 0;
      foreach (v[i]) begin
         a = (v[i] < 0) ? -v[i] : v[i];
         as += sat(a);
         e = sat(v[i] - lvl_of(v[i], r, m));
         es += e;
         ss += longint'(e) * longint'(e);
      end
      rr = int'(as >>> L);
      ea = int'(es >>> L);
      sq = ss >>> L;
   endtask

   task automatic chk(input string tag, input longint got, input longint exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic send_sample(input int v, input bit s);
      @(negedge sys_clk);
      dec_in     = DW'(v);
      sam_clk_en = 1'b1;
      sym_clk_en = s;
      @(negedge sys_clk);
      sam_clk_en = 1'b0;
      sym_clk_en = 1'b0;
   endtask

   task automatic do_sym(input int kind, input int k);
      int s[4];
      int t;
      case (kind)
         0: begin t = clean[k % 4]; s = '{t, t, t, t}; end
         1: begin t = clean[k % 4] + 8192; s = '{t, t, t, t}; end
         2: begin t = (k % 2 == 0) ? 65536 : -65536; s = '{t, t, t, t}; end
         3: begin
            foreach (s[i]) s[i] = int'($urandom_range(0, 262142)) - 131071;
         end
         default: s = '{0, 65536, 0, 0};
      endcase
      for (int i = 0; i < 4; i++) send_sample(s[i], i == 3);
      dvq.push_back(s[3 - int'(phase_sel)]);
   endtask

   task automatic pulse_start();
      @(negedge sys_clk);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
   endtask

   task automatic measure(input int kind, input bit coinc);
      int w[$];
      int m[$];
      int r0, e0, d0, rr, ea;
      longint s0, sq;
      d0 = done_cnt;
      r0 = 0;
      if (coinc) begin
         do_sym(3, 0);
         start = 1'b1;
         @(negedge sys_clk);
         start = 1'b0;
      end else begin
         pulse_start();
      end
      dvq.delete();
      for (int k = 0; k < 2 * N; k++) begin
         if (k == N + 1) chk("no_done_warmup", done_cnt - d0, 0);
         do_sym(kind, k);
         if (k == N - 1) begin
            w = dvq;
            model(w, 0, mode, r0, e0, s0);
         end
         if (k >= N && kind == 2) chk("slice", slice, slc_of(dvq[k], r0, mode));
      end
      @(negedge sys_clk);
      @(negedge sys_clk);
      chk("done_once", done_cnt - d0, 1);
      chk("busy_end", busy, 0);
      for (int k = N; k < 2 * N; k++) m.push_back(dvq[k]);
      model(m, r0, mode, rr, ea, sq);
      chk("ref_lvl", ref_lvl, rr);
      chk("err_avg", err_avg, ea);
      chk("err_sq_avg", err_sq_avg, sq);
   endtask

   initial begin
      int d0, r_cur, r_n, ea;
      longint sq;
      reset      = 1'b1;
      sam_clk_en = 1'b0;
      sym_clk_en = 1'b0;
      dec_in     = '0;
      phase_sel  = '0;
      mode       = 1'b0;
      start      = 1'b0;
      continuous = 1'b0;
      repeat (3) @(negedge sys_clk);
      chk("rst_ref", ref_lvl, 0);
      chk("rst_err", err_avg, 0);
      chk("rst_sq", err_sq_avg, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_slice", slice, 0);
      reset = 1'b0;

      measure(0, 1'b0);
      chk("clean_ref", ref_lvl, 65536);
      chk("clean_err", err_avg, 0);
      chk("clean_sq", err_sq_avg, 0);

      measure(1, 1'b0);
      chk("ofs_ref", ref_lvl, 65536);
      chk("ofs_err", err_avg, 8192);
      chk("ofs_sq", err_sq_avg, longint'(1) << 26);

      mode = 1'b1;
      measure(2, 1'b0);
      chk("ask2_ref", ref_lvl, 65536);
      chk("ask2_err", err_avg, 0);

      mode = 1'b0;
      measure(3, 1'b1);
      mode = 1'b1;
      measure(3, 1'b0);
      mode = 1'b0;

      for (int p = 0; p < PH; p++) begin
         phase_sel = SW'(p);
         measure(4, 1'b0);
         chk("phase_ref", ref_lvl, (p == 2) ? 65536 : 0);
      end
      phase_sel = '0;

      continuous = 1'b1;
      d0 = done_cnt;
      pulse_start();
      dvq.delete();
      for (int k = 0; k < N; k++) do_sym(3, k);
      model(dvq, 0, 1'b0, r_cur, ea, sq);
      for (int w = 0; w < 3; w++) begin
         dvq.delete();
         for (int k = 0; k < N; k++) begin
            if (w == 1 && k == 5) pulse_start();
            if (w == 2 && k == 3) continuous = 1'b0;
            do_sym(3, k);
         end
         @(negedge sys_clk);
         @(negedge sys_clk);
         chk("cont_done", done_cnt - d0, w + 1);
         model(dvq, r_cur, 1'b0, r_n, ea, sq);
         chk("cont_ref", ref_lvl, r_n);
         chk("cont_err", err_avg, ea);
         chk("cont_sq", err_sq_avg, sq);
         chk("cont_busy", busy, (w < 2) ? 1 : 0);
         r_cur = r_n;
      end
      for (int k = 0; k < N; k++) do_sym(3, k);
      repeat (3) @(negedge sys_clk);
      chk("cont_stop_done", done_cnt - d0, 3);
      chk("cont_stop_busy", busy, 0);

      pulse_start();
      for (int k = 0; k < N + 7; k++) do_sym(3, k);
      chk("mid_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_ref", ref_lvl, 0);
      chk("arst_err", err_avg, 0);
      chk("arst_sq", err_sq_avg, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_slice", slice, 0);
      d0 = done_cnt;
      @(negedge sys_clk);
      @(negedge sys_clk);
      reset = 1'b0;
      for (int k = 0; k < N; k++) do_sym(3, k);
      repeat (3) @(negedge sys_clk);
      chk("arst_no_done", done_cnt - d0, 0);
      chk("arst_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
